// File: rtl/mips_debug_unit.sv
// Debug bridge between the MIPS pipeline and the UART.
// Host byte commands gate the pipeline; captured words go out MSB first.
module mips_debug_unit #(
  parameter int         DATA_W   = 32,
  parameter logic [7:0] CMD_RUN  = 8'h52,
  parameter logic [7:0] CMD_HALT = 8'h48,
  parameter logic [7:0] CMD_STEP = 8'h53,
  parameter logic [7:0] CMD_CLR  = 8'h43
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_rx_data,
  input  logic              in_rx_done,
  input  logic              in_capture,
  input  logic [DATA_W-1:0] in_capture_data,
  input  logic              in_tx_done,
  output logic              out_tx_start,
  output logic [7:0]        out_tx_data,
  output logic              out_mips_enable,
  output logic              out_busy,
  output logic              out_overflow
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_word;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic              r_run;
  logic              r_step;
  logic              r_ovf;

  logic w_idle;
  assign w_idle = (r_state == S_IDLE);

  // Host command decode: run/halt mode, pending step, sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run  <= 1'b0;
      r_step <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (r_step && w_idle)
        r_step <= 1'b0;
      if (in_rx_done) begin
        unique case (1'b1)
          (in_rx_data == CMD_RUN):  r_run <= 1'b1;
          (in_rx_data == CMD_HALT): begin
            r_run  <= 1'b0;
            r_step <= 1'b0;
          end
          (in_rx_data == CMD_STEP): begin
            if (!r_run)
              r_step <= 1'b1;
          end
          (in_rx_data == CMD_CLR):  r_ovf <= 1'b0;
          default: ;
        endcase
      end
      // a dropped capture outranks a clear in the same cycle
      if (in_capture && !w_idle)
        r_ovf <= 1'b1;
    end
  end

  // Dump FSM: latch word, then one start/done handshake per byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_word     <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (in_capture) begin
            r_idx      <= '0;
            r_tx_data  <= in_capture_data[DATA_W-1 -: 8];
            r_word     <= in_capture_data << 8;
            r_tx_start <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (in_tx_done) begin
            if (r_idx == LAST) begin
              r_state <= S_IDLE;
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_tx_data  <= r_word[DATA_W-1 -: 8];
              r_word     <= r_word << 8;
              r_tx_start <= 1'b1;
              r_state    <= S_START;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_tx_start    = r_tx_start;
  assign out_tx_data     = r_tx_data;
  assign out_busy        = !w_idle;
  assign out_overflow    = r_ovf;
  assign out_mips_enable = (r_run || r_step) && w_idle;

endmodule

// File: tb/tb_mips_debug_unit.sv
// Directed bench for mips_debug_unit.
// UART done is returned 10 cycles after each start pulse.
module tb_mips_debug_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_rx_data;
  logic        in_rx_done;
  logic        in_capture;
  logic [31:0] in_capture_data;
  logic        in_tx_done;
  logic        out_tx_start;
  logic [7:0]  out_tx_data;
  logic        out_mips_enable;
  logic        out_busy;
  logic        out_overflow;

  int n_err = 0;
  int n_chk = 0;

  mips_debug_unit dut (
    .clk             (clk),
    .rst             (rst),
    .in_rx_data      (in_rx_data),
    .in_rx_done      (in_rx_done),
    .in_capture      (in_capture),
    .in_capture_data (in_capture_data),
    .in_tx_done      (in_tx_done),
    .out_tx_start    (out_tx_start),
    .out_tx_data     (out_tx_data),
    .out_mips_enable (out_mips_enable),
    .out_busy        (out_busy),
    .out_overflow    (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_rx_data = b;
    in_rx_done = 1'b1;
    tick();
    in_rx_done = 1'b0;
  endtask

  task automatic capture(input logic [31:0] w);
    in_capture_data = w;
    in_capture = 1'b1;
    tick();
    in_capture = 1'b0;
  endtask

  // Called one cycle after the capture edge; checks each byte and
  // the quiet gap before its done. inj/stp pick the byte during
  // whose gap a second capture / an 'S' command is injected.
  task automatic dump(input logic [31:0] w, input int inj,
                      input int stp, input int abort_after);
    logic [31:0] ww;
    int bad;
    ww = w;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("start%0d", b), {31'd0, out_tx_start}, 32'd1);
      chk($sformatf("byte%0d", b), {24'd0, out_tx_data},
          {24'd0, ww[31-8*b -: 8]});
      chk($sformatf("busy%0d", b), {31'd0, out_busy}, 32'd1);
      chk($sformatf("en_off%0d", b), {31'd0, out_mips_enable}, 32'd0);
      bad = 0;
      for (int c = 0; c < 9; c++) begin
        if (c == 4 && b == inj) begin
          in_capture_data = 32'h12345678;
          in_capture = 1'b1;
        end
        if (c == 4 && b == stp) begin
          in_rx_data = 8'h53;
          in_rx_done = 1'b1;
        end
        tick();
        in_capture = 1'b0;
        in_rx_done = 1'b0;
        if (out_tx_start !== 1'b0 || out_busy !== 1'b1 ||
            out_mips_enable !== 1'b0 ||
            out_tx_data !== ww[31-8*b -: 8])
          bad++;
      end
      chk($sformatf("gap%0d", b), bad, 0);
      in_tx_done = 1'b1;
      tick();
      in_tx_done = 1'b0;
      if (b == abort_after)
        return;
    end
    chk("busy_end", {31'd0, out_busy}, 32'd0);
    chk("start_end", {31'd0, out_tx_start}, 32'd0);
    chk("data_hold", {24'd0, out_tx_data}, {24'd0, ww[7:0]});
  endtask

  initial begin
    int bad;
    rst = 1'b0;
    in_rx_data = 8'h00;
    in_rx_done = 1'b0;
    in_capture = 1'b0;
    in_capture_data = 32'h0;
    in_tx_done = 1'b0;

    // reset
    tick();
    tick();
    chk("rst_start", {31'd0, out_tx_start}, 32'd0);
    chk("rst_data", {24'd0, out_tx_data}, 32'd0);
    chk("rst_en", {31'd0, out_mips_enable}, 32'd0);
    chk("rst_busy", {31'd0, out_busy}, 32'd0);
    chk("rst_ovf", {31'd0, out_overflow}, 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_en", {31'd0, out_mips_enable}, 32'd0);

    // run / halt
    send(8'h52);
    chk("run_en", {31'd0, out_mips_enable}, 32'd1);
    send(8'h48);
    chk("halt_en", {31'd0, out_mips_enable}, 32'd0);
    send(8'h58);
    chk("junk_en", {31'd0, out_mips_enable}, 32'd0);

    // single step from HALT
    send(8'h53);
    chk("step_en1", {31'd0, out_mips_enable}, 32'd1);
    tick();
    chk("step_en2", {31'd0, out_mips_enable}, 32'd0);
    tick();
    chk("step_en3", {31'd0, out_mips_enable}, 32'd0);

    // step ignored in RUN
    send(8'h52);
    chk("run2_en", {31'd0, out_mips_enable}, 32'd1);
    send(8'h53);
    chk("runstep_en", {31'd0, out_mips_enable}, 32'd1);
    tick();
    chk("runstep_en2", {31'd0, out_mips_enable}, 32'd1);

    // dump in RUN
    capture(32'hDEADBEEF);
    dump(32'hDEADBEEF, -1, -1, -1);
    chk("dump_en_back", {31'd0, out_mips_enable}, 32'd1);
    chk("dump_ovf", {31'd0, out_overflow}, 32'd0);

    // overflow: second capture mid-dump
    capture(32'hDEADBEEF);
    dump(32'hDEADBEEF, 1, -1, -1);
    chk("ovf_set", {31'd0, out_overflow}, 32'd1);
    tick();
    tick();
    chk("ovf_sticky", {31'd0, out_overflow}, 32'd1);
    send(8'h43);
    chk("ovf_clr", {31'd0, out_overflow}, 32'd0);

    // deferred step in HALT
    send(8'h48);
    chk("halt2_en", {31'd0, out_mips_enable}, 32'd0);
    capture(32'hCAFEF00D);
    dump(32'hCAFEF00D, -1, 2, -1);
    chk("dstep_en1", {31'd0, out_mips_enable}, 32'd1);
    tick();
    chk("dstep_en2", {31'd0, out_mips_enable}, 32'd0);

    // reset mid-dump
    send(8'h52);
    capture(32'hDEADBEEF);
    dump(32'hDEADBEEF, -1, -1, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst_data", {24'd0, out_tx_data}, 32'd0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_tx_start !== 1'b0 || out_busy !== 1'b0 ||
          out_mips_enable !== 1'b0)
        bad++;
      tick();
    end
    chk("mrst_quiet", bad, 0);
    capture(32'h00000001);
    dump(32'h00000001, -1, -1, -1);
    chk("mrst_halt", {31'd0, out_mips_enable}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_debug_unit.md
Name: mips_debug_unit

Overview:
- Sits between the MIPS pipeline and the Top_UART block.
- Decodes single-byte host commands received over UART into the pipeline run/halt/step enable.
- Captures 32-bit pipeline result words, such as the execute-stage ALU result, and serialises each one MSB-first into four UART transmit handshakes.
- Stalls the pipeline while a dump is in progress.

Parameters:
- DATA_W, 32, width of captured word; must be a multiple of 8.
- CMD_RUN, 8'h52, command byte 'R': continuous run.
- CMD_HALT, 8'h48, command byte 'H': halt.
- CMD_STEP, 8'h53, command byte 'S': execute one cycle.
- CMD_CLR, 8'h43, command byte 'C': clear overflow flag.

Ports:
- clk  in  1  system clock, all logic on its rising edge
- rst  in  1  synchronous reset, active-low
- in_rx_data  in  8  byte received by the UART
- in_rx_done  in  1  one-cycle pulse; in_rx_data valid in the same cycle
- in_capture  in  1  one-cycle pulse requesting a dump of in_capture_data
- in_capture_data  in  DATA_W  word to transmit, sampled when in_capture=1
- in_tx_done  in  1  one-cycle pulse from the UART; current byte fully sent
- out_tx_start  out  1  one-cycle pulse to start a UART byte transmission
- out_tx_data  out  8  byte to transmit, held stable from the start pulse until the matching done
- out_mips_enable  out  1  pipeline enable (1 = advance)
- out_busy  out  1  high while a dump is in progress (FSM not in IDLE)
- out_overflow  out  1  sticky flag: a capture was dropped

Behaviour:
- Reset (rst=0 at a clock edge): mode=HALT, FSM=IDLE, step_pending=0, byte index=0.
  - out_tx_start=0, out_tx_data=8'h00, out_mips_enable=0, out_busy=0, out_overflow=0.
  - Reset mid-dump abandons the word; no further tx_start pulses.
- Command decode: acts only when in_rx_done=1, at that edge.
  - CMD_RUN sets mode=RUN.
  - CMD_HALT sets mode=HALT and clears step_pending.
  - CMD_STEP in HALT sets step_pending=1; CMD_STEP in RUN is ignored.
  - CMD_CLR clears out_overflow. If an overflow set and CMD_CLR occur in the same cycle, set wins.
  - Any other byte is ignored.
- Enable: out_mips_enable = (mode==RUN or step_pending) and FSM==IDLE, decoded from registers only.
  - Step: out_mips_enable is high for exactly one cycle while IDLE; step_pending clears at that edge.
  - A step issued while busy is held until the FSM returns to IDLE.
  - Command accepted in cycle N -> out_mips_enable reflects it in cycle N+1.
- Dump FSM states: IDLE, START, WAIT.
  - IDLE: in_capture=1 latches the word and sets idx=0; next state START.
  - START: out_tx_start=1 for this single cycle; out_tx_data = byte (DATA_W/8-1-idx), MSB first; next state WAIT.
  - WAIT: in_tx_done is ignored in all other states.
    - On in_tx_done with idx < DATA_W/8-1: idx+1, next state START.
    - On in_tx_done with the last byte: next state IDLE.
  - Capture in cycle N -> first tx_start in cycle N+1.
  - Minimum spacing between successive tx_start pulses: done edge + 1 cycle.
  - out_busy=1 in START and WAIT.
  - out_tx_data is registered and keeps its last value in IDLE.
- Overflow: in_capture=1 while FSM != IDLE drops the new word and sets out_overflow.
  - This includes the cycle in which the final in_tx_done arrives.
  - The word in flight is unaffected.
- Simultaneous in_rx_done and in_capture: both are processed in the same cycle.
  - The enable is still forced 0 from the next cycle because the FSM has left IDLE.
- Implementation: registered outputs, no combinational path from inputs to outputs, no latches.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release.
  - Required: all outputs 0; 'R' byte -> out_mips_enable=1 from the next cycle; 'H' -> 0 the cycle after.
- Single step: from HALT send 'S'.
  - Required: out_mips_enable high exactly 1 cycle.
  - Send 'S' while mode=RUN: no change, enable stays 1.
- Dump: in_capture with 32'hDEADBEEF; bench answers each tx_start with in_tx_done 10 cycles later.
  - Required: exactly 4 tx_start pulses carrying DE, AD, BE, EF in order.
  - Required: out_busy=1 throughout, out_mips_enable=0 during the dump even in RUN, re-asserted after the last done.
- Overflow: second in_capture (32'h12345678) during the dump.
  - Required: bytes remain DE AD BE EF; out_overflow=1 and sticky.
  - Send 'C': out_overflow=0 next cycle.
- Deferred step: 'S' sent mid-dump.
  - Required: enable stays 0 until IDLE, then exactly 1 cycle high.
- Reset mid-dump: rst=0 after the second byte's done.
  - Required: no further tx_start; out_busy=0, mode=HALT, and a new capture of 32'h00000001 sends 00 00 00 01.
